// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the data-memory handshake, resolves branches, and registers MEM/WB.
// Latency: one cycle from a completion event to the MEM/WB outputs; pcsrc/stall_req/dmem_* are combinational.
// Backpressure: stall_req = dmem_req & ~dmem_ack holds EX/MEM; a wait that reaches TIMEOUT aborts with mem_err.
// Optional feature: define MEM_MISALIGN_CHECK_EN to abort word accesses with aluresult[1:0] != 0.

module mem_stage #(
  parameter int TIMEOUT = 255  // max cycles spent in WAIT before abort, 1..255
) (
  input  logic        clk,
  input  logic        rst,
  // EX/MEM register contents
  input  logic [31:0] ext_pc,
  input  logic [31:0] aluresult,
  input  logic [31:0] rt,
  input  logic        zero,
  input  logic        branch,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        regwrite,
  input  logic [4:0]  swdst,
  input  logic [1:0]  memtoreg,
  // data memory port
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  // pipeline control
  output logic        stall_req,
  output logic        pcsrc,
  output logic [31:0] branch_target,
  // MEM/WB register
  output logic [31:0] wb_readdata,
  output logic [31:0] wb_aluresult,
  output logic [4:0]  wb_dst,
  output logic        wb_regwrite,
  output logic [1:0]  wb_memtoreg,
  output logic        wb_valid,
  output logic        mem_err
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Counter value of the last WAIT cycle allowed before the access is aborted.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wcnt_q, wcnt_d;

  logic [31:0] wb_readdata_q, wb_readdata_d;
  logic [31:0] wb_aluresult_q, wb_aluresult_d;
  logic [4:0]  wb_dst_q, wb_dst_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic [1:0]  wb_memtoreg_q, wb_memtoreg_d;
  logic        wb_valid_q, wb_valid_d;
  logic        mem_err_q, mem_err_d;

  logic access;
  logic misalign;
  logic timeout;
  logic abort;
  logic req_c;
  logic stall_c;

  // A simultaneous read and write is issued as a write, since dmem_we follows memwrite.
  assign access = memread | memwrite;

`ifdef MEM_MISALIGN_CHECK_EN
  // Word accesses must be 4-byte aligned; an unaligned one is never sent to memory.
  assign misalign = access & (aluresult[1:0] != 2'b00);
`else
  // Without the check the low address bits go to memory untouched.
  assign misalign = 1'b0;
`endif

  // The final WAIT cycle gives up unless the acknowledge shows up in that same cycle.
  assign timeout = (state_q == WAIT) && !dmem_ack && (wcnt_q == WAIT_LAST);

  // State register and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next-state logic: wait only when a request is outstanding without acknowledge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (access && !misalign && !dmem_ack) state_d = WAIT;
      WAIT:    if (dmem_ack || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Counter reads 0 in the first WAIT cycle and counts up while the wait continues.
    wcnt_d = ((state_q == WAIT) && (state_d == WAIT)) ? wcnt_q + 8'd1 : 8'd0;
  end

  // Output logic: request strobe, stall and branch decision, all gated off during reset.
  always_comb begin
    req_c   = 1'b0;
    stall_c = 1'b0;
    pcsrc   = 1'b0;
    if (!rst) begin
      req_c   = ((state_q == IDLE && access) || state_q == WAIT) && !misalign;
      stall_c = req_c && !dmem_ack;
      pcsrc   = branch && zero && !stall_c;
    end
  end

  assign dmem_req      = req_c;
  assign stall_req     = stall_c;
  assign dmem_addr     = aluresult;
  assign dmem_wdata    = rt;
  assign dmem_we       = memwrite;
  assign branch_target = ext_pc;

  // Abort covers both the timeout and the misaligned-access suppression.
  assign abort = timeout | misalign;

  // MEM/WB next value: bubble while stalled or aborting, otherwise capture the completed op.
  always_comb begin
    wb_readdata_d  = 32'd0;
    wb_aluresult_d = 32'd0;
    wb_dst_d       = 5'd0;
    wb_regwrite_d  = 1'b0;
    wb_memtoreg_d  = 2'd0;
    wb_valid_d     = 1'b0;
    mem_err_d      = 1'b0;
    if (abort) begin
      mem_err_d = 1'b1;
    end else if (!stall_c) begin
      wb_readdata_d  = dmem_rdata;
      wb_aluresult_d = aluresult;
      wb_dst_d       = swdst;
      wb_regwrite_d  = regwrite;
      wb_memtoreg_d  = memtoreg;
      wb_valid_d     = 1'b1;
    end
  end

  // MEM/WB register; reset drops any access in flight without flagging an error.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_readdata_q  <= 32'd0;
      wb_aluresult_q <= 32'd0;
      wb_dst_q       <= 5'd0;
      wb_regwrite_q  <= 1'b0;
      wb_memtoreg_q  <= 2'd0;
      wb_valid_q     <= 1'b0;
      mem_err_q      <= 1'b0;
    end else begin
      wb_readdata_q  <= wb_readdata_d;
      wb_aluresult_q <= wb_aluresult_d;
      wb_dst_q       <= wb_dst_d;
      wb_regwrite_q  <= wb_regwrite_d;
      wb_memtoreg_q  <= wb_memtoreg_d;
      wb_valid_q     <= wb_valid_d;
      mem_err_q      <= mem_err_d;
    end
  end

  assign wb_readdata  = wb_readdata_q;
  assign wb_aluresult = wb_aluresult_q;
  assign wb_dst       = wb_dst_q;
  assign wb_regwrite  = wb_regwrite_q;
  assign wb_memtoreg  = wb_memtoreg_q;
  assign wb_valid     = wb_valid_q;
  assign mem_err      = mem_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vectors with literal expectations plus a per-cycle reference model.
// The model tracks only how long the current request has been outstanding.
// Built with TIMEOUT=4 so the abort path is reached quickly.

module tb_mem_stage;

  localparam int TO = 4;
`ifdef MEM_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ext_pc, aluresult, rt, dmem_rdata;
  logic        zero, branch, memread, memwrite, regwrite, dmem_ack;
  logic [4:0]  swdst;
  logic [1:0]  memtoreg;
  logic        dmem_req, dmem_we, stall_req, pcsrc;
  logic [31:0] dmem_addr, dmem_wdata, branch_target;
  logic [31:0] wb_readdata, wb_aluresult;
  logic [4:0]  wb_dst;
  logic        wb_regwrite, wb_valid, mem_err;
  logic [1:0]  wb_memtoreg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ext_pc(ext_pc), .aluresult(aluresult), .rt(rt),
    .zero(zero), .branch(branch), .memread(memread), .memwrite(memwrite),
    .regwrite(regwrite), .swdst(swdst), .memtoreg(memtoreg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall_req(stall_req), .pcsrc(pcsrc), .branch_target(branch_target),
    .wb_readdata(wb_readdata), .wb_aluresult(wb_aluresult), .wb_dst(wb_dst),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_valid(wb_valid),
    .mem_err(mem_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    ext_pc = 0; aluresult = 0; rt = 0; dmem_rdata = 0;
    zero = 0; branch = 0; memread = 0; memwrite = 0; regwrite = 0;
    dmem_ack = 0; swdst = 0; memtoreg = 0;
  endtask

  // Reference model state: expected MEM/WB contents and request age.
  bit          known = 1'b0;
  int          age = 0;  // cycles the current request has already been outstanding
  logic [31:0] e_rd, e_alu, e_dst, e_rw, e_mtr, e_valid, e_err;

  // Compare on the falling edge, then advance the model across the coming rising edge.
  always @(negedge clk) begin : model
    bit acc, mis, inreq, stl, tmo;
    acc   = memread | memwrite;
    mis   = MIS && acc && (aluresult[1:0] != 2'b00);
    inreq = !rst && acc && !mis;
    stl   = inreq && !dmem_ack;
    // First request cycle has age 0, so the abort falls on request cycle TO+1.
    tmo   = stl && (age == TO);
    if (known) begin
      check("m_dmem_req", 32'(dmem_req), 32'(inreq));
      check("m_stall_req", 32'(stall_req), 32'(stl));
      check("m_pcsrc", 32'(pcsrc), 32'(!rst && branch && zero && !stl));
      check("m_branch_target", branch_target, ext_pc);
      if (inreq) begin
        check("m_dmem_addr", dmem_addr, aluresult);
        check("m_dmem_wdata", dmem_wdata, rt);
        check("m_dmem_we", 32'(dmem_we), 32'(memwrite));
      end
      check("m_wb_readdata", wb_readdata, e_rd);
      check("m_wb_aluresult", wb_aluresult, e_alu);
      check("m_wb_dst", 32'(wb_dst), e_dst);
      check("m_wb_regwrite", 32'(wb_regwrite), e_rw);
      check("m_wb_memtoreg", 32'(wb_memtoreg), e_mtr);
      check("m_wb_valid", 32'(wb_valid), e_valid);
      check("m_mem_err", 32'(mem_err), e_err);
    end
    if (rst) begin
      {e_rd, e_alu, e_dst, e_rw, e_mtr, e_valid, e_err} = '0;
      age   = 0;
      known = 1'b1;
    end else begin
      if (tmo || mis) begin
        {e_rd, e_alu, e_dst, e_rw, e_mtr, e_valid} = '0;
        e_err = 1;
      end else if (stl) begin
        {e_rd, e_alu, e_dst, e_rw, e_mtr, e_valid, e_err} = '0;
      end else begin
        e_rd = dmem_rdata; e_alu = aluresult; e_dst = 32'(swdst);
        e_rw = 32'(regwrite); e_mtr = 32'(memtoreg); e_valid = 1; e_err = 0;
      end
      age = (stl && !tmo) ? age + 1 : 0;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear();
    rst = 1;
    branch = 1; zero = 1;   // pcsrc must still be held low in reset
    tick(); tick();
    check("rst_wb_valid", 32'(wb_valid), 0);
    check("rst_mem_err", 32'(mem_err), 0);
    check("rst_wb_readdata", wb_readdata, 0);
    check("rst_dmem_req", 32'(dmem_req), 0);
    check("rst_pcsrc", 32'(pcsrc), 0);
    rst = 0;
    clear();
    tick();

    // Zero-wait load
    memread = 1; aluresult = 32'h100; dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    regwrite = 1; swdst = 5'd3; memtoreg = 2'd1;
    #1;
    check("zw_stall", 32'(stall_req), 0);
    check("zw_req", 32'(dmem_req), 1);
    tick();
    clear();
    #1;
    check("zw_wb_readdata", wb_readdata, 32'hDEADBEEF);
    check("zw_wb_valid", 32'(wb_valid), 1);
    check("zw_wb_dst", 32'(wb_dst), 3);
    check("zw_wb_alu", wb_aluresult, 32'h100);
    check("zw_wb_mtr", 32'(wb_memtoreg), 1);

    // Three-wait store, acknowledged in the 4th request cycle
    memwrite = 1; rt = 32'h12345678; aluresult = 32'h200;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("st_stall", 32'(stall_req), 1);
      check("st_we", 32'(dmem_we), 1);
      check("st_wdata", dmem_wdata, 32'h12345678);
      if (i > 0) check("st_bubble", 32'(wb_valid), 0);
      tick();
    end
    dmem_ack = 1;
    #1;
    check("st_ack_stall", 32'(stall_req), 0);
    check("st_ack_wdata", dmem_wdata, 32'h12345678);
    check("st_bubble3", 32'(wb_valid), 0);
    tick();
    clear();
    #1;
    check("st_done_valid", 32'(wb_valid), 1);
    check("st_done_alu", wb_aluresult, 32'h200);

    // Timeout: TO=4 gives 5 request cycles, then a bubble and a single mem_err pulse
    memread = 1; aluresult = 32'h300;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("to_req", 32'(dmem_req), 1);
      check("to_err_low", 32'(mem_err), 0);
      tick();
    end
    clear();
    #1;
    check("to_err_pulse", 32'(mem_err), 1);
    check("to_bubble", 32'(wb_valid), 0);
    tick();
    check("to_err_once", 32'(mem_err), 0);

    // Acknowledge in the would-be timeout cycle wins
    memread = 1; aluresult = 32'h304; dmem_rdata = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) tick();
    dmem_ack = 1;
    #1;
    check("tp_stall", 32'(stall_req), 0);
    tick();
    clear();
    #1;
    check("tp_no_err", 32'(mem_err), 0);
    check("tp_valid", 32'(wb_valid), 1);
    check("tp_rdata", wb_readdata, 32'hCAFEF00D);

    // Branch resolution
    branch = 1; zero = 1; ext_pc = 32'h40;
    #1;
    check("br_taken", 32'(pcsrc), 1);
    check("br_target", branch_target, 32'h40);
    tick();
    zero = 0;
    #1;
    check("br_not_taken", 32'(pcsrc), 0);
    tick();
    zero = 1; memread = 1; aluresult = 32'h400;
    #1;
    check("br_stalled", 32'(pcsrc), 0);
    tick();
    dmem_ack = 1;
    #1;
    check("br_after_ack", 32'(pcsrc), 1);
    tick();
    clear();

    // Back-to-back zero-wait loads: one completion per cycle
    for (int i = 0; i < 4; i++) begin
      memread = 1; aluresult = 32'h500 + 32'(4 * i); dmem_rdata = 32'hA0000000 + 32'(i);
      swdst = 5'(i + 1); regwrite = 1; dmem_ack = 1;
      #1;
      check("b2b_stall", 32'(stall_req), 0);
      if (i > 0) begin
        check("b2b_valid", 32'(wb_valid), 1);
        check("b2b_rdata", wb_readdata, 32'hA0000000 + 32'(i - 1));
      end
      tick();
    end
    clear();
    #1;
    check("b2b_last", wb_readdata, 32'hA0000003);

    // Read and write together is a write
    memread = 1; memwrite = 1; aluresult = 32'h600; rt = 32'h55AA55AA; dmem_ack = 1;
    #1;
    check("rw_we", 32'(dmem_we), 1);
    tick();
    clear();

    // Reset during the 2nd WAIT cycle, then a late acknowledge
    memread = 1; aluresult = 32'h700;
    tick();
    tick();
    rst = 1;
    #1;
    check("rmw_req", 32'(dmem_req), 0);
    check("rmw_stall", 32'(stall_req), 0);
    tick();
    dmem_ack = 1;
    #1;
    check("rmw_req_ack", 32'(dmem_req), 0);
    tick();
    rst = 0;
    clear();
    #1;
    check("rmw_valid", 32'(wb_valid), 0);
    check("rmw_rdata", wb_readdata, 0);
    check("rmw_dst", 32'(wb_dst), 0);
    check("rmw_err", 32'(mem_err), 0);
    tick();
    memread = 1; aluresult = 32'h704;
    tick();
    dmem_ack = 1;
    tick();
    clear();

    // Misaligned address
`ifdef MEM_MISALIGN_CHECK_EN
    memread = 1; aluresult = 32'h102;
    #1;
    check("mis_req", 32'(dmem_req), 0);
    check("mis_stall", 32'(stall_req), 0);
    tick();
    clear();
    #1;
    check("mis_err", 32'(mem_err), 1);
    check("mis_bubble", 32'(wb_valid), 0);
`else
    memread = 1; aluresult = 32'h102; dmem_ack = 1; dmem_rdata = 32'h0BADF00D;
    #1;
    check("mis_req", 32'(dmem_req), 1);
    check("mis_addr", dmem_addr, 32'h102);
    tick();
    clear();
    #1;
    check("mis_err", 32'(mem_err), 0);
    check("mis_valid", 32'(wb_valid), 1);
    check("mis_alu", wb_aluresult, 32'h102);
`endif
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
